raytracing_row_writer: RTL and testbench

Downstream stage of the raytracing worker array. After every worker has finished its batch of jobs, this block captures the per-worker color buffers and drains them as an ordered, addressed pixel stream into the framebuffer write port. It undoes the worker interleave: worker `w`, job `j` maps to pixel `x = pixel_start_x + j*N_WORKERS + w`. Pixels go out in strictly increasing `x`.

---
 rtl/raytracing_row_writer_if.sv | 27 ++
 rtl/raytracing_row_writer.sv | 153 +++++++++++++++
 tb/tb_raytracing_row_writer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/raytracing_row_writer_if.sv
// Framebuffer write port shared by the row writer and the framebuffer.
//   wr_valid : beat presented (master -> slave)
//   wr_ready : beat accepted  (slave -> master)
//   wr_addr  : linear framebuffer address, ADDR_B bits
//   wr_data  : 12-bit {R,G,B} pixel color
interface raytracing_row_writer_if #(
  parameter int unsigned ADDR_B = 17
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_B-1:0] wr_addr;
  logic [11:0]       wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/raytracing_row_writer.sv
// Captures the per-worker color buffers once a batch is finished and drains
// them as an ordered pixel stream (increasing x) into the framebuffer port,
// undoing the worker interleave: x = pixel_start_x + j*N_WORKERS + w.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   worker_buffers  : colors, worker w job j at bit (w*JOBS_SUBDIVISION+j)*12
//   pixel_start_x   : x of worker 0 job 0;  pixel_y : row of the batch
//   capture_valid/capture_ready : batch capture handshake (ready only in idle)
//   wr              : framebuffer write port (master side)
//   row_done        : one-cycle pulse after the last beat of a batch
//   overflow        : sticky, capture requested while not ready
module raytracing_row_writer #(
  parameter int unsigned N_WORKERS        = 4,
  parameter int unsigned JOBS_SUBDIVISION = 16,
  parameter int unsigned FB_WIDTH         = 320,
  parameter int unsigned FB_HEIGHT        = 240,
  parameter int unsigned ADDR_B           = 17
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*12-1:0]  worker_buffers,
  input  logic [11:0]                               pixel_start_x,
  input  logic [11:0]                               pixel_y,
  input  logic                                      capture_valid,
  output logic                                      capture_ready,
  raytracing_row_writer_if.master                   wr,
  output logic                                      row_done,
  output logic                                      overflow
);

  localparam int unsigned NPix = N_WORKERS * JOBS_SUBDIVISION;
  localparam int unsigned WW   = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int unsigned JW   = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
  localparam int unsigned IW   = (NPix > 1) ? $clog2(NPix) : 1;
  // One extra bit so pixel_start_x + NPix never wraps before the clip compare.
  localparam int unsigned XW   = 13;

  if ((64'(1) << ADDR_B) < 64'(FB_WIDTH) * 64'(FB_HEIGHT)) begin : gen_addr_check
    $error("ADDR_B too small for FB_WIDTH*FB_HEIGHT");
  end

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  state_e            state_q;
  logic [11:0]       color_q [NPix];
  logic [XW-1:0]     x_q;
  logic [WW-1:0]     w_q;
  logic [JW-1:0]     j_q;
  logic [ADDR_B-1:0] addr_q;
  logic [11:0]       data_q;
  logic              valid_q;
  logic              ready_q;
  logic              done_q;
  logic              ovf_q;

  logic              last_beat;
  logic [WW-1:0]     w_nx;
  logic [JW-1:0]     j_nx;
  logic [IW-1:0]     idx_nx;
  logic [XW-1:0]     x_nx;
  logic [ADDR_B-1:0] base_addr;
  logic              start_in_row;

  always_comb begin
    last_beat = (w_q == WW'(N_WORKERS - 1)) && (j_q == JW'(JOBS_SUBDIVISION - 1));
    w_nx      = w_q + WW'(1);
    j_nx      = j_q;
    if (w_q == WW'(N_WORKERS - 1)) begin
      w_nx = '0;
      j_nx = j_q + JW'(1);
    end
    // Only meaningful when last_beat is low; the last beat never reads it.
    idx_nx       = IW'(32'(w_nx) * JOBS_SUBDIVISION + 32'(j_nx));
    x_nx         = x_q + XW'(1);
    base_addr    = ADDR_B'(pixel_y) * ADDR_B'(FB_WIDTH) + ADDR_B'(pixel_start_x);
    start_in_row = {1'b0, pixel_start_x} < XW'(FB_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      w_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (capture_valid && !ready_q) begin
        ovf_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (capture_valid) begin
            for (int unsigned i = 0; i < NPix; i++) begin
              color_q[i] <= worker_buffers[i*12 +: 12];
            end
            x_q     <= {1'b0, pixel_start_x};
            w_q     <= '0;
            j_q     <= '0;
            addr_q  <= base_addr;
            data_q  <= worker_buffers[11:0];
            valid_q <= start_in_row;
            ready_q <= 1'b0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!valid_q) begin
            // Start was already past the row end: nothing to write.
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (wr.wr_ready) begin
            x_q    <= x_nx;
            w_q    <= w_nx;
            j_q    <= j_nx;
            addr_q <= addr_q + ADDR_B'(1);
            if (last_beat || (x_nx >= XW'(FB_WIDTH))) begin
              // Final beat, or the rest of the batch falls off the row.
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              data_q <= color_q[idx_nx];
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign capture_ready = ready_q;
  assign wr.wr_valid   = valid_q;
  assign wr.wr_addr    = addr_q;
  assign wr.wr_data    = data_q;
  assign row_done      = done_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_raytracing_row_writer.sv
// Directed bench for raytracing_row_writer with default parameters: unclipped
// drain, random backpressure, row-end clipping, zero-beat batch, overflow and
// mid-drain reset. Inputs are driven and outputs sampled on the falling edge.
module tb_raytracing_row_writer;

  localparam int NW  = 4;
  localparam int NJ  = 16;
  localparam int FBW = 320;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NW*NJ*12-1:0]   worker_buffers = '0;
  logic [11:0]           pixel_start_x = '0;
  logic [11:0]           pixel_y = '0;
  logic                  capture_valid = 1'b0;
  logic                  capture_ready;
  logic                  row_done;
  logic                  overflow;

  int n_cmp = 0;
  int n_err = 0;

  raytracing_row_writer_if #(.ADDR_B(17)) wr_if ();

  raytracing_row_writer #(
    .N_WORKERS        (NW),
    .JOBS_SUBDIVISION (NJ),
    .FB_WIDTH         (FBW),
    .FB_HEIGHT        (240),
    .ADDR_B           (17)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .worker_buffers (worker_buffers),
    .pixel_start_x  (pixel_start_x),
    .pixel_y        (pixel_y),
    .capture_valid  (capture_valid),
    .capture_ready  (capture_ready),
    .wr             (wr_if),
    .row_done       (row_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] color(input int pat, input int w, input int j);
    logic [3:0] wv;
    logic [3:0] jv;
    wv = 4'(w);
    jv = 4'(j);
    if (pat == 0) return {wv, jv, 4'hA};
    return {~jv, wv, 4'h5};
  endfunction

  function automatic logic [NW*NJ*12-1:0] make_buf(input int pat);
    logic [NW*NJ*12-1:0] b;
    b = '0;
    for (int w = 0; w < NW; w++) begin
      for (int j = 0; j < NJ; j++) begin
        b[(w*NJ+j)*12 +: 12] = color(pat, w, j);
      end
    end
    return b;
  endfunction

  // One batch: capture, then collect beats until row_done. ovf_iter >= 0 pulses
  // capture_valid mid-drain; rst_beat >= 0 resets right after that beat.
  task automatic run_batch(input string name, input int start, input int y, input int pat,
                           input int exp_beats, input bit bp, input int ovf_iter,
                           input int rst_beat);
    int          k;
    int          iter;
    int          last_iter;
    int          seen;
    bit          done;
    bit          stall;
    bit          hit_rst;
    logic [16:0] hold_addr;
    logic [11:0] hold_data;

    @(negedge clk);
    worker_buffers  = make_buf(pat);
    pixel_start_x   = 12'(start);
    pixel_y         = 12'(y);
    capture_valid   = 1'b1;
    wr_if.wr_ready  = 1'b0;
    check_eq({name, ".ready_idle"}, 32'(capture_ready), 32'd1);
    @(negedge clk);
    capture_valid  = 1'b0;
    worker_buffers = '1;  // latched copy must not follow the input
    k = 0; iter = 0; last_iter = -1; done = 1'b0; stall = 1'b0; hit_rst = 1'b0;
    hold_addr = '0; hold_data = '0;

    while (!done && iter < 400) begin
      if (iter == 0) begin
        check_eq({name, ".first_valid"}, 32'(wr_if.wr_valid), 32'(exp_beats > 0));
        check_eq({name, ".busy"}, 32'(capture_ready), 32'd0);
      end
      capture_valid = (iter == ovf_iter);
      if (hit_rst) begin
        wr_if.wr_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq({name, ".rst_valid"}, 32'(wr_if.wr_valid), 32'd0);
        check_eq({name, ".rst_ready"}, 32'(capture_ready), 32'd1);
        check_eq({name, ".rst_ovf"}, 32'(overflow), 32'd0);
        check_eq({name, ".rst_addr"}, 32'(wr_if.wr_addr), 32'd0);
        seen = 0;
        repeat (6) begin
          @(negedge clk);
          if (row_done) seen++;
        end
        check_eq({name, ".rst_no_done"}, 32'(seen), 32'd0);
        return;
      end
      if (stall) begin
        check_eq({name, ".hold_valid"}, 32'(wr_if.wr_valid), 32'd1);
        check_eq({name, ".hold_addr"}, 32'(wr_if.wr_addr), 32'(hold_addr));
        check_eq({name, ".hold_data"}, 32'(wr_if.wr_data), 32'(hold_data));
      end
      if (row_done) begin
        done = 1'b1;
        check_eq({name, ".beats"}, 32'(k), 32'(exp_beats));
        if (exp_beats == NW*NJ) check_eq({name, ".done_lat"}, 32'(iter), 32'(last_iter + 1));
        if (exp_beats == 0) check_eq({name, ".done_lat0"}, 32'(iter), 32'd1);
      end else begin
        wr_if.wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (wr_if.wr_valid && wr_if.wr_ready) begin
          check_eq({name, ".addr"}, 32'(wr_if.wr_addr), 32'(y*FBW + start + k));
          check_eq({name, ".data"}, 32'(wr_if.wr_data), 32'(color(pat, k % NW, k / NW)));
          last_iter = iter;
          hit_rst   = (k == rst_beat);
          k++;
        end
        stall     = wr_if.wr_valid && !wr_if.wr_ready;
        hold_addr = wr_if.wr_addr;
        hold_data = wr_if.wr_data;
        @(negedge clk);
        iter++;
      end
    end
    capture_valid = 1'b0;
    check_eq({name, ".finished"}, 32'(done), 32'd1);
    if (done) begin
      wr_if.wr_ready = 1'b0;
      @(negedge clk);
      check_eq({name, ".ready_back"}, 32'(capture_ready), 32'd1);
    end
  endtask

  initial begin
    wr_if.wr_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset.ready", 32'(capture_ready), 32'd1);
    check_eq("reset.valid", 32'(wr_if.wr_valid), 32'd0);
    check_eq("reset.addr", 32'(wr_if.wr_addr), 32'd0);
    check_eq("reset.data", 32'(wr_if.wr_data), 32'd0);
    check_eq("reset.done", 32'(row_done), 32'd0);
    check_eq("reset.ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    run_batch("base", 0, 2, 0, 64, 1'b0, -1, -1);
    run_batch("bp", 0, 2, 1, 64, 1'b1, -1, -1);
    run_batch("clip", 300, 0, 0, 20, 1'b0, -1, -1);
    run_batch("zero", 320, 0, 0, 0, 1'b0, -1, -1);
    check_eq("pre_ovf.ovf", 32'(overflow), 32'd0);
    run_batch("ovf", 64, 5, 1, 64, 1'b0, 7, -1);
    check_eq("ovf.sticky", 32'(overflow), 32'd1);
    run_batch("post", 256, 1, 0, 64, 1'b0, -1, -1);
    check_eq("post.sticky", 32'(overflow), 32'd1);
    run_batch("rst", 0, 3, 0, 64, 1'b0, -1, 10);
    run_batch("restart", 0, 2, 1, 64, 1'b0, -1, -1);
    check_eq("end.ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
